rob_flushable: RTL and testbench

- Parametrised reorder buffer that holds per-instruction payloads (old physical-register aliases) in program order.
- Allocates up to PUSH_WIDTH entries per cycle and marks entries done from CMPL_PORTS completion ports.
- Retires up to POP_WIDTH consecutive done entries per cycle, in order.
- Adds flush-to-entry recovery for failed terminators: all entries younger than a given entry are squashed. It replaces the fixed-configuration ROB in the out-of-order core.

---
 rtl/rob_flushable.sv | 203 ++++++++++++++++++++
 tb/tb_rob_flushable.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_flushable.sv
// -----------------------------------------------------------------------------
// rob_flushable
//   Reorder buffer holding one payload (old physical-register alias) per
//   in-flight instruction, kept in program order. Up to PUSH_WIDTH entries are
//   allocated per cycle at the tail, CMPL_PORTS completion ports mark entries
//   done, and up to POP_WIDTH consecutive done entries retire from the head.
//   A flush keeps flush_entry and everything older, squashing all younger
//   entries; a same-cycle push is dropped, a same-cycle retirement proceeds.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   din, din_valid    push payload lanes and thermometer push mask
//   din_ready_ct      lanes that can be accepted this cycle
//   entry_nums        entry number each push lane would receive
//   dout              payloads at head, oldest in lane 0
//   dout_valid_ct     consecutive done entries at head (capped)
//   dout_ready_ct     lanes taken by the consumer
//   completed         per-port completed entry number
//   cmplt_valid       per-port completion strobe
//   flush_valid       squash everything younger than flush_entry
//   flush_entry       youngest surviving entry
//   count             current occupancy
// -----------------------------------------------------------------------------
module rob_flushable #(
    parameter int DATA_WIDTH = 11,
    parameter int PUSH_WIDTH = 4,
    parameter int POP_WIDTH  = 3,
    parameter int ELEMENTS   = 15,
    parameter int CMPL_PORTS = 3,
    parameter int IDX_W      = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0]    din,
    input  logic [PUSH_WIDTH-1:0]               din_valid,
    output logic [$clog2(PUSH_WIDTH+1)-1:0]     din_ready_ct,
    output logic [PUSH_WIDTH*IDX_W-1:0]         entry_nums,
    output logic [POP_WIDTH*DATA_WIDTH-1:0]     dout,
    output logic [$clog2(POP_WIDTH+1)-1:0]      dout_valid_ct,
    input  logic [$clog2(POP_WIDTH+1)-1:0]      dout_ready_ct,
    input  logic [CMPL_PORTS*IDX_W-1:0]         completed,
    input  logic [CMPL_PORTS-1:0]               cmplt_valid,
    input  logic                                flush_valid,
    input  logic [IDX_W-1:0]                    flush_entry,
    output logic [$clog2(ELEMENTS+1)-1:0]       count
);

    localparam int PCW = $clog2(PUSH_WIDTH+1);
    localparam int RCW = $clog2(POP_WIDTH+1);
    localparam int CW  = $clog2(ELEMENTS+1);
    // Storage is addressed with just enough bits for ELEMENTS slots.
    localparam int AW  = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
    // Wide enough to hold index + offset (both <= ELEMENTS) without overflow.
    localparam int SW  = IDX_W + 2;
    localparam logic [SW-1:0] E_S    = SW'(ELEMENTS);
    localparam logic [SW-1:0] PUSH_S = SW'(PUSH_WIDTH);

    // Index arithmetic wraps modulo ELEMENTS, not modulo 2^IDX_W.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input logic [SW-1:0]    off);
        logic [SW-1:0] s;
        s = SW'(base) + off;
        if (s >= E_S) s = s - E_S;
        return s[IDX_W-1:0];
    endfunction

    // Age of entry 'to' relative to 'from' (0 = oldest).
    function automatic logic [SW-1:0] idx_dist(input logic [IDX_W-1:0] from,
                                               input logic [IDX_W-1:0] to);
        logic [SW-1:0] d;
        if (to >= from) d = SW'(to) - SW'(from);
        else            d = SW'(to) + E_S - SW'(from);
        return d;
    endfunction

    function automatic logic [AW-1:0] slot(input logic [IDX_W-1:0] i);
        return i[AW-1:0];
    endfunction

    logic [IDX_W-1:0]      head_q, head_d;
    logic [IDX_W-1:0]      tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ELEMENTS-1:0]   done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q [ELEMENTS];

    logic [PUSH_WIDTH-1:0] wr_en;
    logic [AW-1:0]         wr_slot [PUSH_WIDTH];

    logic [SW-1:0]         count_s, free_s, keep_s, ret_s, push_s, pos_s;
    logic [PCW-1:0]        push_req, push_ct;
    logic [RCW-1:0]        vld_ct, ret_ct;
    logic                  run;
    logic [IDX_W-1:0]      e_idx, lane_idx;

    always_comb begin
        count_s = SW'(count_q);
        free_s  = E_S - count_s;

        din_ready_ct = (free_s < PUSH_S) ? PCW'(free_s) : PCW'(PUSH_WIDTH);

        push_req = '0;
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            push_req = push_req + PCW'(din_valid[k]);
        end
        push_ct = (push_req < din_ready_ct) ? push_req : din_ready_ct;
        // A flush drops the whole push in the same cycle.
        if (flush_valid) push_ct = '0;

        entry_nums = '0;
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            entry_nums[k*IDX_W +: IDX_W] = idx_add(tail_q, SW'(k));
        end

        dout = '0;
        for (int k = 0; k < POP_WIDTH; k++) begin
            dout[k*DATA_WIDTH +: DATA_WIDTH] = data_q[slot(idx_add(head_q, SW'(k)))];
        end

        // Count the unbroken run of done entries from head, within occupancy.
        vld_ct   = '0;
        run      = 1'b1;
        lane_idx = head_q;
        for (int k = 0; k < POP_WIDTH; k++) begin
            lane_idx = idx_add(head_q, SW'(k));
            if (run && (SW'(k) < count_s) && done_q[slot(lane_idx)]) begin
                vld_ct = vld_ct + RCW'(1);
            end else begin
                run = 1'b0;
            end
        end
        dout_valid_ct = vld_ct;

        ret_ct = (vld_ct < dout_ready_ct) ? vld_ct : dout_ready_ct;

        // Number of entries that survive a flush (head .. flush_entry).
        keep_s = idx_dist(head_q, flush_entry) + SW'(1);
        // Retiring past flush_entry would take squashed work; never let the
        // retirement reach beyond the survivors.
        if (flush_valid && (SW'(ret_ct) > keep_s)) ret_ct = RCW'(keep_s);

        ret_s  = SW'(ret_ct);
        push_s = SW'(push_ct);

        head_d = idx_add(head_q, ret_s);
        if (flush_valid) begin
            tail_d  = idx_add(flush_entry, SW'(1));
            count_d = CW'(keep_s - ret_s);
        end else begin
            tail_d  = idx_add(tail_q, push_s);
            count_d = CW'(count_s + push_s - ret_s);
        end

        done_d = done_q;
        e_idx  = '0;
        pos_s  = '0;
        for (int c = 0; c < CMPL_PORTS; c++) begin
            e_idx = completed[c*IDX_W +: IDX_W];
            pos_s = idx_dist(head_q, e_idx);
            // Only entries occupied before this edge and surviving any flush.
            if (cmplt_valid[c] && (SW'(e_idx) < E_S) && (pos_s < count_s) &&
                !(flush_valid && (pos_s >= keep_s))) begin
                done_d[slot(e_idx)] = 1'b1;
            end
        end

        for (int k = 0; k < POP_WIDTH; k++) begin
            if (SW'(k) < ret_s) done_d[slot(idx_add(head_q, SW'(k)))] = 1'b0;
        end

        wr_en = '0;
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            wr_slot[k] = slot(idx_add(tail_q, SW'(k)));
            if (SW'(k) < push_s) begin
                wr_en[k]            = 1'b1;
                done_d[wr_slot[k]]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset: it is only observed behind done bits.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            if (wr_en[k]) data_q[wr_slot[k]] <= din[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_rob_flushable.sv
module tb_rob_flushable;

    localparam int DW  = 11;
    localparam int PW  = 4;
    localparam int RW  = 3;
    localparam int E   = 15;
    localparam int CP  = 3;
    localparam int IW  = 5;
    localparam int PCW = $clog2(PW+1);
    localparam int RCW = $clog2(RW+1);
    localparam int CW  = $clog2(E+1);

    logic               clk = 1'b0;
    logic               rst;
    logic [PW*DW-1:0]   din;
    logic [PW-1:0]      din_valid;
    logic [PCW-1:0]     din_ready_ct;
    logic [PW*IW-1:0]   entry_nums;
    logic [RW*DW-1:0]   dout;
    logic [RCW-1:0]     dout_valid_ct;
    logic [RCW-1:0]     dout_ready_ct;
    logic [CP*IW-1:0]   completed;
    logic [CP-1:0]      cmplt_valid;
    logic               flush_valid;
    logic [IW-1:0]      flush_entry;
    logic [CW-1:0]      count;

    rob_flushable #(
        .DATA_WIDTH(DW), .PUSH_WIDTH(PW), .POP_WIDTH(RW),
        .ELEMENTS(E), .CMPL_PORTS(CP), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .din(din), .din_valid(din_valid), .din_ready_ct(din_ready_ct),
        .entry_nums(entry_nums), .dout(dout), .dout_valid_ct(dout_valid_ct),
        .dout_ready_ct(dout_ready_ct), .completed(completed),
        .cmplt_valid(cmplt_valid), .flush_valid(flush_valid),
        .flush_entry(flush_entry), .count(count)
    );

    always #5 clk = ~clk;

    // Reference: a program-ordered queue of live instructions.
    typedef struct { int id; int pay; bit done; } ent_t;
    ent_t q[$];
    int   m_tail;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int m_vct();
        int n = 0;
        for (int k = 0; k < RW && k < q.size(); k++) begin
            if (!q[k].done) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
    endtask

    task automatic compare_all();
        int vct;
        vct = m_vct();
        chk("count", int'(count), q.size());
        chk("din_ready_ct", int'(din_ready_ct), min2(E - q.size(), PW));
        for (int k = 0; k < PW; k++)
            chk($sformatf("entry_nums[%0d]", k), int'(entry_nums[k*IW +: IW]), (m_tail + k) % E);
        chk("dout_valid_ct", int'(dout_valid_ct), vct);
        for (int k = 0; k < vct; k++)
            chk($sformatf("dout[%0d]", k), int'(dout[k*DW +: DW]), q[k].pay);
    endtask

    task automatic idle();
        din           = '0;
        din_valid     = '0;
        dout_ready_ct = '0;
        completed     = '0;
        cmplt_valid   = '0;
        flush_valid   = 1'b0;
        flush_entry   = '0;
    endtask

    task automatic set_push(input int n, input int base);
        din_valid = PW'((1 << n) - 1);
        for (int k = 0; k < PW; k++) din[k*DW +: DW] = DW'(base + k);
    endtask

    task automatic set_cmpl(input int port, input int e);
        cmplt_valid[port]         = 1'b1;
        completed[port*IW +: IW]  = IW'(e);
    endtask

    // Apply the driven inputs to the model, clock the DUT, compare.
    task automatic cycle();
        int v, size0, r, j, keep, pushes, e;
        v     = int'(din_valid);
        size0 = q.size();
        assert (((v + 1) & v) == 0) else $error("din_valid not thermometer: %b", din_valid);
        j = -1;
        if (flush_valid) begin
            for (int i = 0; i < q.size(); i++)
                if (q[i].id == int'(flush_entry)) j = i;
            assert (j >= 0) else $error("flush_entry %0d not occupied", flush_entry);
        end
        r = min2(m_vct(), int'(dout_ready_ct));
        if (flush_valid) assert (r <= j + 1) else $error("retire beyond flush_entry");
        for (int c = 0; c < CP; c++) begin
            if (cmplt_valid[c]) begin
                e = int'(completed[c*IW +: IW]);
                for (int i = 0; i < q.size(); i++)
                    if (q[i].id == e && (!flush_valid || i <= j)) q[i].done = 1'b1;
            end
        end
        for (int i = 0; i < r; i++) void'(q.pop_front());
        if (flush_valid) begin
            keep = j + 1 - r;
            while (q.size() > keep) void'(q.pop_back());
            m_tail = (int'(flush_entry) + 1) % E;
        end else begin
            pushes = min2($countones(din_valid), min2(E - size0, PW));
            for (int k = 0; k < pushes; k++) begin
                q.push_back('{id: m_tail, pay: int'(din[k*DW +: DW]), done: 1'b0});
                m_tail = (m_tail + 1) % E;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int n, j, r, phase;
        idle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        chk("rst_ready", int'(din_ready_ct), 4);
        chk("rst_entry3", int'(entry_nums[3*IW +: IW]), 3);
        chk("rst_vct", int'(dout_valid_ct), 0);
        chk("rst_count", int'(count), 0);

        // Allocate entries 0..3.
        idle(); set_push(4, 100); cycle();
        chk("alloc_count", int'(count), 4);
        chk("alloc_en0", int'(entry_nums[0 +: IW]), 4);
        chk("alloc_en3", int'(entry_nums[3*IW +: IW]), 7);
        chk("alloc_vct", int'(dout_valid_ct), 0);

        // Out-of-order completion: 2, then 0, then 1.
        idle(); set_cmpl(0, 2); cycle();
        chk("cmpl2_vct", int'(dout_valid_ct), 0);
        idle(); set_cmpl(1, 0); cycle();
        chk("cmpl0_vct", int'(dout_valid_ct), 1);
        idle(); set_cmpl(2, 1); cycle();
        chk("cmpl1_vct", int'(dout_valid_ct), 3);
        chk("cmpl1_dout0", int'(dout[0 +: DW]), 100);
        chk("cmpl1_dout2", int'(dout[2*DW +: DW]), 102);
        idle(); dout_ready_ct = 3; cycle();
        chk("retire3_count", int'(count), 1);
        chk("retire3_vct", int'(dout_valid_ct), 0);

        // Grow to head=3, tail=9, count=6 then flush at entry 5.
        idle(); set_push(4, 200); cycle();
        idle(); set_push(1, 204); cycle();
        chk("pre_flush_count", int'(count), 6);
        chk("pre_flush_en0", int'(entry_nums[0 +: IW]), 9);
        idle(); flush_valid = 1'b1; flush_entry = 5; cycle();
        chk("flush_count", int'(count), 3);
        chk("flush_en0", int'(entry_nums[0 +: IW]), 6);
        chk("flush_en3", int'(entry_nums[3*IW +: IW]), 9);
        idle(); set_cmpl(0, 7); cycle();
        chk("squashed_cmpl_vct", int'(dout_valid_ct), 0);
        chk("squashed_cmpl_count", int'(count), 3);

        // Flush + push + retire in one cycle.
        idle(); set_cmpl(1, 3); cycle();
        chk("e3_done_vct", int'(dout_valid_ct), 1);
        chk("e3_dout0", int'(dout[0 +: DW]), 103);
        idle(); flush_valid = 1'b1; flush_entry = 5; set_push(4, 300); dout_ready_ct = 1; cycle();
        chk("combo_count", int'(count), 2);
        chk("combo_en0", int'(entry_nums[0 +: IW]), 6);
        chk("combo_dout0", int'(dout[0 +: DW]), 200);

        // Fill to full, then retire and push together while full.
        for (int i = 0; i < 4; i++) begin
            idle(); set_push(4, 400 + 4*i); cycle();
        end
        chk("full_count", int'(count), 15);
        chk("full_ready", int'(din_ready_ct), 0);
        chk("full_en0", int'(entry_nums[0 +: IW]), 4);
        idle(); set_cmpl(0, 4); set_cmpl(1, 5); cycle();
        chk("full_vct", int'(dout_valid_ct), 2);
        idle(); dout_ready_ct = 2; set_push(4, 500); cycle();
        chk("full_retire_ready", int'(din_ready_ct), 2);
        chk("full_retire_count", int'(count), 13);
        idle(); set_push(2, 600); cycle();
        chk("refill_count", int'(count), 15);

        // Randomized traffic against the queue model.
        phase = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) phase = $urandom_range(0, 2);
            idle();
            n = $urandom_range(0, PW);
            if (phase == 1 && ($urandom % 4) != 0) n = 0;
            din_valid = PW'((1 << n) - 1);
            for (int k = 0; k < PW; k++) din[k*DW +: DW] = DW'($urandom);
            dout_ready_ct = RCW'($urandom_range(0, RW));
            if (phase == 2 && ($urandom % 3) == 0) dout_ready_ct = '0;
            for (int c = 0; c < CP; c++) begin
                if (($urandom % 3) != 0) begin
                    if (q.size() > 0 && ($urandom % 4) != 0)
                        set_cmpl(c, q[$urandom_range(0, q.size() - 1)].id);
                    else
                        set_cmpl(c, $urandom_range(0, (1 << IW) - 1));
                end
            end
            if (q.size() > 0 && ($urandom % 12) == 0) begin
                j = $urandom_range(0, q.size() - 1);
                flush_valid = 1'b1;
                flush_entry = IW'(q[j].id);
                r = min2(m_vct(), int'(dout_ready_ct));
                if (r > j + 1) dout_ready_ct = RCW'(j + 1);
            end
            cycle();
        end

        // Asynchronous reset in the middle of a burst.
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        idle(); set_push(4, 700); cycle();
        idle(); set_push(4, 710); cycle();
        idle(); set_push(2, 720); cycle();
        chk("burst_count", int'(count), 10);
        idle(); set_push(4, 730);
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_ready", int'(din_ready_ct), 4);
        chk("async_vct", int'(dout_valid_ct), 0);
        chk("async_en2", int'(entry_nums[2*IW +: IW]), 2);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        compare_all();
        set_push(1, 55); cycle();
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_en0", int'(entry_nums[0 +: IW]), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
